// File: rtl/long_to_double_if.sv
// ---------------------------------------------------------------------------
// long_to_double_if
//   Handshake bundle for the long_to_double converter: the integer operand
//   channel (input_a / input_a_stb / input_a_ack) and the binary64 result
//   channel (output_z / output_z_stb / output_z_ack).
//
//   modport master : the producer/consumer side (drives the operand and the
//                    result acknowledge)
//   modport slave  : the converter side (drives the operand acknowledge and
//                    the result with its strobe)
// ---------------------------------------------------------------------------
interface long_to_double_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

// File: rtl/long_to_double.sv
// ---------------------------------------------------------------------------
// long_to_double
//   Converts a signed 64-bit two's-complement integer into an IEEE-754
//   binary64 value, rounding to nearest with ties to even. Single-entry,
//   multi-cycle: one operand is taken, converted and handed out before the
//   next operand is accepted.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; discards any in-flight work
//     bus    long_to_double_if.slave
//              input_a      64-bit signed operand
//              input_a_stb  operand valid
//              input_a_ack  converter ready (transfer on stb & ack edge)
//              output_z     binary64 result
//              output_z_stb result valid
//              output_z_ack consumer accepts (transfer on stb & ack edge)
// ---------------------------------------------------------------------------
module long_to_double (
  input  logic             clk,
  input  logic             rst_n,
  long_to_double_if.slave  bus
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [63:0] a_reg;
  logic        sign;
  logic [63:0] m;
  logic [6:0]  e;
  logic [51:0] mantissa;
  logic        ack_reg;
  logic        stb_reg;
  logic [63:0] z_reg;

  logic [63:0] magnitude;
  logic        guard_bit;
  logic        round_bit;
  logic        sticky_bit;
  logic        round_up;
  logic        mant_carry;
  logic [51:0] mant_inc;
  logic [10:0] biased_exp;

  // |a| as an unsigned value; -2^63 negates onto itself, which is exactly
  // the 0x8000_0000_0000_0000 magnitude we want.
  assign magnitude = a_reg[63] ? (~a_reg + 64'd1) : a_reg;

  // Bits below the 53-bit significand decide the rounding direction.
  assign guard_bit  = m[10];
  assign round_bit  = m[9];
  assign sticky_bit = |m[8:0];
  assign round_up   = guard_bit & (round_bit | sticky_bit | m[11]);

  // Incrementing {1,mantissa} carries out exactly when the stored 52-bit
  // fraction is all ones, in which case the fraction wraps to zero.
  assign {mant_carry, mant_inc} = {1'b0, m[62:11]} + 53'd1;

  assign biased_exp = {4'b0000, e} + 11'd1023;

  assign bus.input_a_ack  = ack_reg;
  assign bus.output_z_stb = stb_reg;
  assign bus.output_z     = z_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; NORMALISE loops until the leading one reaches bit 63.
  always_comb begin
    next_state = state;
    case (state)
      GET_A:     if (ack_reg && bus.input_a_stb) next_state = CONVERT;
      CONVERT:   next_state = (magnitude == 64'd0) ? PUT_Z : NORMALISE;
      NORMALISE: if (m[63]) next_state = ROUND;
      ROUND:     next_state = PACK;
      PACK:      next_state = PUT_Z;
      PUT_Z:     if (stb_reg && bus.output_z_ack) next_state = GET_A;
      default:   next_state = GET_A;
    endcase
  end

  // Datapath and registered handshake outputs. The result strobe is raised
  // on the edge that enters PUT_Z so the result is visible without an extra
  // idle cycle, and the operand ack is re-raised one edge after returning to
  // GET_A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= 64'd0;
      sign     <= 1'b0;
      m        <= 64'd0;
      e        <= 7'd0;
      mantissa <= 52'd0;
      ack_reg  <= 1'b0;
      stb_reg  <= 1'b0;
      z_reg    <= 64'd0;
    end else begin
      case (state)
        GET_A: begin
          if (ack_reg && bus.input_a_stb) begin
            a_reg   <= bus.input_a;
            ack_reg <= 1'b0;
          end else begin
            ack_reg <= 1'b1;
          end
        end
        CONVERT: begin
          sign <= a_reg[63];
          m    <= magnitude;
          e    <= 7'd63;
          // Zero has no leading one; emit +0.0 directly.
          if (magnitude == 64'd0) begin
            z_reg   <= 64'd0;
            stb_reg <= 1'b1;
          end
        end
        NORMALISE: begin
          if (!m[63]) begin
            m <= {m[62:0], 1'b0};
            e <= e - 7'd1;
          end
        end
        ROUND: begin
          if (round_up) begin
            mantissa <= mant_inc;
            if (mant_carry) e <= e + 7'd1;
          end else begin
            mantissa <= m[62:11];
          end
        end
        PACK: begin
          z_reg   <= {sign, biased_exp, mantissa};
          stb_reg <= 1'b1;
        end
        PUT_Z: begin
          if (stb_reg && bus.output_z_ack) stb_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_long_to_double.sv
// ---------------------------------------------------------------------------
// tb_long_to_double
//   Directed bench for long_to_double: reset state, exact conversions,
//   extreme magnitudes, ties-to-even, result backpressure, asynchronous
//   reset during a conversion, then a batch of random operands checked
//   against the simulator's own integer-to-real conversion.
// ---------------------------------------------------------------------------
module tb_long_to_double;

  logic clk = 1'b0;
  logic rst_n;

  long_to_double_if bus ();

  long_to_double dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int totalCount = 0;
  int passCount  = 0;

  // Hard stop in case the design wedges somewhere no bounded wait covers.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
  endtask

  task automatic flagTimeout(input string tag);
    totalCount++;
    $error("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  function automatic int leadingZeros(input logic [63:0] v);
    int n = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  // Presents one operand, waits for the capture, then counts edges until
  // the result strobe appears. Returns with the result pending.
  task automatic applyStimulus(input logic [63:0] value, output int latency);
    int waitCycles = 0;
    latency = 0;
    @(negedge clk);
    while (bus.input_a_ack !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (bus.input_a_ack !== 1'b1) begin
      flagTimeout("input_ack");
      return;
    end
    bus.input_a     = value;
    bus.input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
    checkOutput("ack_drop", 64'(bus.input_a_ack), 64'd0);
    while (latency < 100) begin
      if (bus.output_z_stb === 1'b1) break;
      @(posedge clk);
      #1;
      latency++;
    end
    if (bus.output_z_stb !== 1'b1) flagTimeout("output_stb");
  endtask

  // Accepts the pending result with a single-cycle ack.
  task automatic acceptOutput();
    @(negedge clk);
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.output_z_ack = 1'b0;
    checkOutput("stb_drop", 64'(bus.output_z_stb), 64'd0);
    checkOutput("ack_after_put", 64'(bus.input_a_ack), 64'd0);
  endtask

  task automatic runVector(input string tag, input logic [63:0] value,
                           input logic [63:0] expZ, input int expLatency);
    int latency;
    applyStimulus(value, latency);
    checkOutput({tag, "_z"}, bus.output_z, expZ);
    checkOutput({tag, "_lat"}, 64'(latency), 64'(expLatency));
    acceptOutput();
  endtask

  initial begin
    logic [63:0] heldZ;
    logic [63:0] raw;
    logic [63:0] mag;
    longint      sv;
    real         refReal;
    int          latency;
    int          waitCycles;

    bus.input_a      = 64'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    rst_n            = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("reset_ack", 64'(bus.input_a_ack), 64'd0);
    checkOutput("reset_stb", 64'(bus.output_z_stb), 64'd0);
    checkOutput("reset_z", bus.output_z, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ack_rise", 64'(bus.input_a_ack), 64'd1);

    // A stray result ack while nothing is pending must change nothing.
    bus.output_z_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ack_stb", 64'(bus.output_z_stb), 64'd0);
    checkOutput("idle_ack_ready", 64'(bus.input_a_ack), 64'd1);
    bus.output_z_ack = 1'b0;

    // Basic values and extreme magnitudes.
    runVector("one", 64'd1, 64'h3FF0000000000000, 67);
    runVector("minus_one", 64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 67);
    runVector("zero", 64'd0, 64'h0000000000000000, 1);
    runVector("three", 64'd3, 64'h4008000000000000, 66);
    runVector("min_int", 64'h8000000000000000, 64'hC3E0000000000000, 4);
    runVector("max_int", 64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 5);

    // Ties to even: 2^53+1 stays, 2^53+3 rounds up.
    runVector("tie_down", 64'd9007199254740993, 64'h4340000000000000, 14);
    runVector("tie_up", 64'd9007199254740995, 64'h4340000000000002, 14);

    // Backpressure: result must hold and new operands must be ignored.
    applyStimulus(64'd5, latency);
    checkOutput("bp_z", bus.output_z, 64'h4014000000000000);
    checkOutput("bp_lat", 64'(latency), 64'd65);
    heldZ = bus.output_z;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.input_a     = 64'd77 + 64'(i);
      bus.input_a_stb = 1'b1;
      checkOutput("bp_hold_z", bus.output_z, heldZ);
      checkOutput("bp_hold_stb", 64'(bus.output_z_stb), 64'd1);
      checkOutput("bp_hold_ready", 64'(bus.input_a_ack), 64'd0);
    end
    bus.input_a_stb = 1'b0;
    acceptOutput();
    runVector("after_bp", 64'd2, 64'h4000000000000000, 66);

    // Asynchronous reset in the middle of normalisation.
    waitCycles = 0;
    @(negedge clk);
    while (bus.input_a_ack !== 1'b1 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (bus.input_a_ack !== 1'b1) flagTimeout("reset_mid_ack");
    bus.input_a     = 64'd1;
    bus.input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_ack", 64'(bus.input_a_ack), 64'd0);
    checkOutput("mid_reset_stb", 64'(bus.output_z_stb), 64'd0);
    checkOutput("mid_reset_z", bus.output_z, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runVector("post_reset", 64'd2, 64'h4000000000000000, 66);

    // Random operands against the simulator's integer-to-real conversion.
    for (int n = 0; n < 200; n++) begin
      raw = {$urandom, $urandom};
      raw = raw >> $urandom_range(0, 63);
      sv  = longint'(raw);
      if ($urandom_range(0, 1) == 1) sv = -sv;
      refReal = real'(sv);
      mag = (sv < 0) ? 64'(-sv) : 64'(sv);
      runVector("random", 64'(sv), $realtobits(refReal),
                (mag == 64'd0) ? 1 : leadingZeros(mag) + 4);
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
